// File: rtl/fifo_wr_arb_ctrl_pkg.sv
// Shared constants and requester IDs for the FIFO write-arbiter controller.
package fifo_wr_arb_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH = 8;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned FIFO_AW = addr_w(FIFO_DEPTH);
    // One extra wrap bit distinguishes full from empty when the address bits match.
    localparam int unsigned FIFO_PW = FIFO_AW + 1;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port FIFO storage: write at w_clk edge, registered read data at r_clk edge.
// Latency: 1 cycle read. Backpressure: ignores writes when full and reads when empty.
module fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             w_clk,
    input  logic             r_clk,
    input  logic             wr_rq,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    waddr,
    input  logic             full,
    input  logic             rd_rq,
    input  logic [AW-1:0]    raddr,
    input  logic             empty,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge w_clk) begin
        if (wr_rq && !full) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge r_clk) begin
        if (rd_rq && !empty) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from req and enable.
// Latency: 0 cycles. Backpressure: enable low suppresses all grants and freezes priority.
module rr_arb2
    import fifo_wr_arb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    req_id_e last_gnt_q;
    req_id_e last_gnt_d;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (last_gnt_q == REQ1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt[0]) begin
            last_gnt_d = REQ0;
        end else if (gnt[1]) begin
            last_gnt_d = REQ1;
        end
    end

    // Reset to REQ1 so producer 0 wins the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= REQ1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// FIFO controller with 2-producer round-robin write arbitration around fifo_mem.
// Latency: grants/rd_ack combinational, rdata and rd_valid one cycle after rd_ack.
// Backpressure: full blocks grants, empty blocks rd_ack. Optional FIFO_ERR_FLAGS_EN adds ovf/udf.
module fifo_wr_arb_ctrl
    import fifo_wr_arb_ctrl_pkg::*;
#(
    parameter int  WIDTH    = 4,
    parameter int  DEPTH    = FIFO_DEPTH,
    parameter int  AF_LEVEL = 6,
    localparam int AW       = addr_w(DEPTH),
    localparam int PW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt1,
    input  logic             rd_rq,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_wr_rq,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [AW-1:0]    mem_waddr,
    output logic             mem_rd_rq,
    output logic [AW-1:0]    mem_raddr,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    count,
`ifdef FIFO_ERR_FLAGS_EN
    output logic             ovf,
    output logic             udf,
`endif
    output logic             almost_full
);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          rd_valid_q;
    logic [1:0]    gnt;
    logic          wr_fire;

    // Flags come only from registered pointers, never from the requests.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .enable (!full),
        .gnt    (gnt)
    );

    assign gnt0      = gnt[REQ0];
    assign gnt1      = gnt[REQ1];
    assign wr_fire   = gnt0 | gnt1;
    assign rd_ack    = rd_rq & ~empty;

    assign mem_wr_rq = wr_fire;
    assign mem_wdata = gnt1 ? data1 : data0;
    assign mem_waddr = wptr_q[AW-1:0];
    assign mem_rd_rq = rd_ack;
    assign mem_raddr = rptr_q[AW-1:0];

    assign count       = count_q;
    assign almost_full = (count_q >= PW'(AF_LEVEL));
    assign rd_valid    = rd_valid_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_fire) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_ack) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({wr_fire, rd_ack})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_ack;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ((req0 | req1) & full);
            udf_q <= udf_q | (rd_rq & empty);
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .w_clk (clk),
        .r_clk (clk),
        .wr_rq (mem_wr_rq),
        .wdata (mem_wdata),
        .waddr (mem_waddr),
        .full  (full),
        .rd_rq (mem_rd_rq),
        .raddr (mem_raddr),
        .empty (empty),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Bench for fifo_wr_arb_ctrl: queue-based reference model compared every cycle, plus directed pins.
module tb_fifo_wr_arb_ctrl;

    localparam int WIDTH    = 4;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AW       = 3;
    localparam int PW       = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0, rd_rq = 1'b0;
    logic [WIDTH-1:0] data0 = '0, data1 = '0;
    logic             gnt0, gnt1, rd_ack, rd_valid;
    logic [WIDTH-1:0] rdata, mem_wdata;
    logic             mem_wr_rq, mem_rd_rq, full, empty, almost_full;
    logic [AW-1:0]    mem_waddr, mem_raddr;
    logic [PW-1:0]    count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             ovf, udf;
`endif

    fifo_wr_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .data0       (data0),
        .gnt0        (gnt0),
        .req1        (req1),
        .data1       (data1),
        .gnt1        (gnt1),
        .rd_rq       (rd_rq),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rdata       (rdata),
        .mem_wr_rq   (mem_wr_rq),
        .mem_wdata   (mem_wdata),
        .mem_waddr   (mem_waddr),
        .mem_rd_rq   (mem_rd_rq),
        .mem_raddr   (mem_raddr),
        .full        (full),
        .empty       (empty),
        .count       (count),
`ifdef FIFO_ERR_FLAGS_EN
        .ovf         (ovf),
        .udf         (udf),
`endif
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue; addresses are running totals modulo DEPTH.
    logic [WIDTH-1:0] q[$];
    int               m_last;
    int               wcnt, rcnt;
    bit               m_rdv;
    logic [WIDTH-1:0] m_rdata;
    bit               m_ovf, m_udf;
    bit               chk_en = 1'b0;

    task automatic model_reset();
        q.delete();
        m_last = 1;
        wcnt   = 0;
        rcnt   = 0;
        m_rdv  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    bit e_full, e_empty, e_g0, e_g1, e_ack;
    int n;

    always @(negedge clk) begin
        if (chk_en) begin
            n       = q.size();
            e_full  = (n == DEPTH);
            e_empty = (n == 0);
            e_g0    = 1'b0;
            e_g1    = 1'b0;
            if (!e_full) begin
                if (req0 && req1) begin
                    if (m_last == 1) e_g0 = 1'b1;
                    else             e_g1 = 1'b1;
                end else begin
                    e_g0 = req0;
                    e_g1 = req1;
                end
            end
            e_ack = rd_rq && (n > 0);

            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("rd_ack", rd_ack, e_ack);
            chk("mem_rd_rq", mem_rd_rq, e_ack);
            chk("mem_wr_rq", mem_wr_rq, e_g0 | e_g1);
            if (e_g0 || e_g1) chk("mem_wdata", mem_wdata, e_g1 ? data1 : data0);
            chk("mem_waddr", mem_waddr, wcnt % DEPTH);
            chk("mem_raddr", mem_raddr, rcnt % DEPTH);
            chk("full", full, e_full);
            chk("empty", empty, e_empty);
            chk("count", count, n);
            chk("almost_full", almost_full, n >= AF_LEVEL);
            chk("rd_valid", rd_valid, m_rdv);
            if (m_rdv) chk("rdata", rdata, m_rdata);
`ifdef FIFO_ERR_FLAGS_EN
            chk("ovf", ovf, m_ovf);
            chk("udf", udf, m_udf);
            m_ovf = m_ovf | ((req0 | req1) && e_full);
            m_udf = m_udf | (rd_rq && e_empty);
`endif
            m_rdv = e_ack;
            if (e_ack) begin
                m_rdata = q.pop_front();
                rcnt++;
            end
            if (e_g0) begin
                q.push_back(data0);
                wcnt++;
                m_last = 0;
            end
            if (e_g1) begin
                q.push_back(data1);
                wcnt++;
                m_last = 1;
            end
        end
    end

    task automatic drive(input logic r0, input logic [WIDTH-1:0] d0,
                         input logic r1, input logic [WIDTH-1:0] d1, input logic rd);
        req0  = r0;
        data0 = d0;
        req1  = r1;
        data1 = d1;
        rd_rq = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        chk_en = 1'b0;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        reset_dut();
        #1;
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset almost_full", almost_full, 0);
        chk("reset rd_valid", rd_valid, 0);

        // Fill with 1..8 from producer 0
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, WIDTH'(i), 0, 0, 0);
            #1 chk("fill gnt0", gnt0, 1);
            step();
        end
        drive(1, 4'h9, 0, 0, 0);
        #1;
        chk("full gnt0", gnt0, 0);
        chk("full flag", full, 1);
        chk("full count", count, 8);
        chk("full almost_full", almost_full, 1);
        step();

        // Full with read and both writes: read wins this cycle
        drive(1, 4'h3, 1, 4'h4, 1);
        #1;
        chk("fullrw rd_ack", rd_ack, 1);
        chk("fullrw gnt0", gnt0, 0);
        chk("fullrw gnt1", gnt1, 0);
        step();
        chk("fullrw count7", count, 7);
        drive(1, 4'h3, 1, 4'h4, 0);
        #1 chk("retry grant", gnt0 | gnt1, 1);
        step();
        chk("retry count8", count, 8);
        drive(0, 0, 0, 0, 1);
        repeat (DEPTH + 1) step();

        // Alternating grants from empty
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'hA, 1, 4'h5, 0);
            #1;
            chk("rr gnt0", gnt0, (i % 2) == 0);
            chk("rr gnt1", gnt1, (i % 2) == 1);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1);
            #1 chk("rr rd_ack", rd_ack, 1);
            step();
            chk("rr rd_valid", rd_valid, 1);
            chk("rr rdata", rdata, (i % 2) ? 4'h5 : 4'hA);
        end

        // Empty with read and write: write wins, no fall-through
        drive(0, 0, 1, 4'hC, 1);
        #1;
        chk("emptyrw rd_ack", rd_ack, 0);
        chk("emptyrw gnt1", gnt1, 1);
        step();
        chk("emptyrw count", count, 1);
        drive(0, 0, 0, 0, 1);
        #1 chk("emptyrw rd_ack2", rd_ack, 1);
        step();
        chk("emptyrw rd_valid", rd_valid, 1);
        chk("emptyrw rdata", rdata, 4'hC);

        // Streaming through two address wraps
        drive(1, WIDTH'($urandom), 0, 0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1, WIDTH'($urandom), 0, 0, 1);
            step();
        end
        chk("stream count", count, 1);
        drive(0, 0, 0, 0, 1);
        repeat (2) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 55), WIDTH'($urandom),
                  ($urandom_range(0, 99) < 45), WIDTH'($urandom),
                  ($urandom_range(0, 99) < 40));
            step();
        end

        // Async reset mid-stream with count=5 and rd_valid=1
        drive(0, 0, 0, 0, 1);
        step();
        drive(1, 0, 1, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        repeat (DEPTH + 1) step();
        for (int i = 0; i < 6; i++) begin
            drive(1, WIDTH'($urandom), 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        chk("pre-reset count", count, 5);
        chk("pre-reset rd_valid", rd_valid, 1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async empty", empty, 1);
        chk("async count", count, 0);
        chk("async rd_valid", rd_valid, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("async ovf", ovf, 0);
        chk("async udf", udf, 0);
`endif
        model_reset();
        step();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        drive(1, 4'h7, 1, 4'h8, 0);
        #1 chk("post-reset priority", gnt0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        repeat (3) step();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fifo_wr_arb_ctrl.md
Name: fifo_wr_arb_ctrl

Overview:
- Single-clock controller and 2-requester write arbiter for the fifo_mem storage block, with w_clk and r_clk both tied to clk.
- Arbitrates two producers round-robin onto one write port.
- Generates the write/read addresses, full/empty flags and occupancy count, and sequences reads.
- Flags rdata validity, because fifo_mem returns data one cycle after a read request.

Parameters:
- WIDTH, 4, data word width; must match fifo_mem WIDTH.
- DEPTH, 8, number of FIFO entries; power of two, minimum 2; must match fifo_mem DEPTH.
- AF_LEVEL, 6, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock; drives this block and both fifo_mem clocks.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  producer 0 write request.
- data0  in  WIDTH  producer 0 write data.
- gnt0  out  1  producer 0 write accepted this cycle (combinational).
- req1  in  1  producer 1 write request.
- data1  in  WIDTH  producer 1 write data.
- gnt1  out  1  producer 1 write accepted this cycle (combinational).
- rd_rq  in  1  consumer read request.
- rd_ack  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  fifo_mem rdata is valid this cycle (registered).
- mem_wr_rq  out  1  to fifo_mem wr_rq.
- mem_wdata  out  WIDTH  to fifo_mem wdata.
- mem_waddr  out  $clog2(DEPTH)  to fifo_mem waddr.
- mem_rd_rq  out  1  to fifo_mem rd_rq.
- mem_raddr  out  $clog2(DEPTH)  to fifo_mem raddr.
- full  out  1  to fifo_mem full, and visible to producers.
- empty  out  1  to fifo_mem empty, and visible to the consumer.
- count  out  $clog2(DEPTH)+1  current occupancy.
- almost_full  out  1  asserted when count >= AF_LEVEL.

Behaviour:
- Reset (async, rst_n=0):
  - wptr=0, rptr=0, count=0, last_gnt=1 (so producer 0 wins first), rd_valid=0.
  - Therefore empty=1, full=0, almost_full=0.
- Pointers:
  - $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - mem_waddr and mem_raddr are the pointer LSBs.
  - Pointers wrap modulo 2*DEPTH.
- Flags:
  - empty = (wptr == rptr).
  - full = LSBs equal and MSBs differ.
  - Both are decoded from registered pointers; neither has a combinational path from the requests.
- Arbitration:
  - Writes are allowed only when full=0.
  - One requester: it is granted.
  - Both requesting: the requester not in last_gnt is granted.
  - last_gnt updates only on an accepted write.
  - At most one gnt per cycle; gnt0 and gnt1 are both 0 when full.
- Write path:
  - mem_wr_rq = gnt0|gnt1; mem_wdata is muxed from the granted requester.
  - wptr increments at the clock edge after the grant.
  - Data is written to fifo_mem at that same edge.
- Read path:
  - rd_ack = rd_rq & ~empty; mem_rd_rq = rd_ack.
  - rptr increments at the same edge.
  - rd_valid is registered from rd_ack, so it is high in the cycle after rd_ack.
  - rdata from fifo_mem is sampled while rd_valid=1.
  - Read latency is one cycle.
- count: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- Boundary conditions:
  - Full with read and write requests in the same cycle: read accepted, write rejected. The producer retries and is granted next cycle.
  - Empty with read and write requests in the same cycle: write accepted, read rejected. No fall-through.
  - Requests may drop without being granted; no state is held for an ungranted request.
  - Reset mid-operation discards all contents, clears rd_valid immediately, and restores producer 0 priority.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds outputs ovf and udf, both 1-bit sticky registers, reset to 0.
  - ovf sets when (req0|req1) && full.
  - udf sets when rd_rq && empty.
  - Both clear only on reset.
- Undefined: the ports and logic are absent; arbitration and data path are unchanged.

Decomposition:
- Shared package holds:
  - the address-width and pointer-width constants, derived from DEPTH;
  - the requester ID encoding (REQ0=0, REQ1=1).
- Sub-module rr_arb2 implements the 2-way round-robin arbiter:
  - inputs: req[1:0], enable (= ~full);
  - outputs: gnt[1:0];
  - holds the internal last_gnt register.
- The top level holds the pointers, flags, count and mux, and instantiates fifo_mem.

Test Plan (WIDTH=4, DEPTH=8, AF_LEVEL=6):
1. After reset, req0 only writes 0x1..0x8 on consecutive cycles:
   - gnt0=1 for 8 cycles, then full=1 and gnt0=0;
   - count=8; almost_full asserted from count=6.
2. req0 and req1 held together from empty, data0=0xA, data1=0x5, then 4 reads:
   - grants alternate 0,1,0,1;
   - read data is A,5,A,5, with rd_valid one cycle after each rd_ack.
3. Full FIFO; rd_rq, req0 and req1 in the same cycle:
   - rd_ack=1, gnt0=gnt1=0, count goes to 7;
   - next cycle a grant is issued and count returns to 8.
4. Empty FIFO; rd_rq and req1 in the same cycle:
   - rd_ack=0, gnt1=1, count=1;
   - next cycle rd_ack=1, and data1 appears with rd_valid.
5. Write/read 20 words streaming (one write and one read per cycle after 1 preload):
   - pointers wrap through addr 7→0 twice;
   - all data is returned in order; count stays at 1.
6. Assert rst_n=0 mid-stream with count=5 and rd_valid=1:
   - outputs return immediately, without waiting for clk, to empty=1, count=0, rd_valid=0;
   - with FIFO_ERR_FLAGS_EN, ovf and udf are also cleared.
